// File: rtl/cska_pkg.sv
// Shared definitions for the word-serial multi-precision adder.
package cska_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BLK_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/cska16.sv
// 16-bit carry-skip adder built from 4-bit ripple blocks with block bypass.
module cska16
  import cska_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic [WORD_W-1:0] Sum,
  output logic              Cout
);

  localparam int unsigned N_BLK = WORD_W / BLK_W;

  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] g;
  logic [N_BLK:0]    blk_c;

  assign p = A ^ B;
  assign g = A & B;

  // Ripple inside each block; a fully propagating block passes its carry-in straight on.
  always_comb begin
    logic c;
    Sum      = '0;
    blk_c    = '0;
    c        = 1'b0;
    blk_c[0] = Cin;
    for (int unsigned j = 0; j < N_BLK; j++) begin
      c = blk_c[j];
      for (int unsigned i = 0; i < BLK_W; i++) begin
        Sum[j*BLK_W+i] = p[j*BLK_W+i] ^ c;
        c              = g[j*BLK_W+i] | (p[j*BLK_W+i] & c);
      end
      blk_c[j+1] = (&p[j*BLK_W +: BLK_W]) ? blk_c[j] : c;
    end
  end

  assign Cout = blk_c[N_BLK];

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract: one 16-bit word per cycle, LSB first.
module mp_add_seq
  import cska_pkg::*;
#(
  parameter int unsigned N_WORDS = 4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Start,
  input  logic                        Sub,
  input  logic [WORD_W*N_WORDS-1:0]   A,
  input  logic [WORD_W*N_WORDS-1:0]   B,
  input  logic                        Cin,
  output logic                        Ready,
  output logic                        Busy,
  output logic                        Done,
  output logic [WORD_W*N_WORDS-1:0]   Sum,
  output logic                        Cout,
  output logic                        Ovf
);

  localparam int unsigned TOT_W = WORD_W * N_WORDS;
  localparam int unsigned CNT_W = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  state_e             state_q;
  state_e             state_d;
  logic               accept;
  logic               last_word;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  op_e                op_q;
  logic [TOT_W-1:0]   a_q;
  logic [TOT_W-1:0]   b_q;
  logic [WORD_W-1:0]  word_a;
  logic [WORD_W-1:0]  word_b_raw;
  logic [WORD_W-1:0]  word_b;
  logic [WORD_W-1:0]  add_sum;
  logic               add_cout;
  logic               ready_d;
  logic               busy_d;
  logic               done_d;

  assign accept    = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_word = (state_q == ST_RUN) && (cnt_q == LAST);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN:  if (last_word) state_d = ST_DONE;
      ST_DONE: state_d = Start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags decoded from the upcoming state so they register in step with it.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_IDLE: ready_d = 1'b1;
      ST_RUN:  busy_d  = 1'b1;
      ST_DONE: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: ready_d = 1'b0;
    endcase
  end

  // Status flag registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Ready <= ready_d;
      Busy  <= busy_d;
      Done  <= done_d;
    end
  end

  // Select the current word of each operand; B is inverted for subtraction.
  always_comb begin
    word_a     = '0;
    word_b_raw = '0;
    for (int unsigned k = 0; k < N_WORDS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        word_a     = a_q[k*WORD_W +: WORD_W];
        word_b_raw = b_q[k*WORD_W +: WORD_W];
      end
    end
    word_b = (op_q == OP_SUB) ? ~word_b_raw : word_b_raw;
  end

  cska16 u_add (
    .Sum  (add_sum),
    .Cout (add_cout),
    .A    (word_a),
    .B    (word_b),
    .Cin  (carry_q)
  );

  // Operand capture on accept, then one word written per RUN cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      op_q    <= Sub ? OP_SUB : OP_ADD;
      cnt_q   <= '0;
      carry_q <= Sub ? 1'b1 : Cin;
    end else if (state_q == ST_RUN) begin
      for (int unsigned k = 0; k < N_WORDS; k++) begin
        if (cnt_q == CNT_W'(k)) Sum[k*WORD_W +: WORD_W] <= add_sum;
      end
      carry_q <= add_cout;
      if (last_word) begin
        Cout <= add_cout;
        Ovf  <= (word_a[WORD_W-1] == word_b[WORD_W-1]) &&
                (add_sum[WORD_W-1] != word_a[WORD_W-1]);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
